// File: rtl/regfile_pkg.sv
// Purpose : shared constants and helpers for the parametrised register file.
// Latency : n/a (compile-time helpers only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int BYTE = 8;

  // Ceiling log2. DEPTH is a power of two of at least 2, so this is exact.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // LSB of slice `port` inside a packed vector of equal `width` slices.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Purpose : write port and read-address/enable bundle of the register file.
// Latency : n/a (wires only).
// Backpressure: none; the register file accepts every write and read each cycle.
// Signals : wr_en/wr_addr/wr_be/wr_data write port, rd_addr packed read addresses,
//           rd_oe per-port output enable. master = datapath side, slave = register file.
interface regfile_param_if import regfile_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) ();

  localparam int AW = clog2(DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WIDTH/BYTE-1:0]    wr_be;
  logic [WIDTH-1:0]         wr_data;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD-1:0]        rd_oe;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_addr, rd_oe
  );

  modport slave (
    input wr_en, wr_addr, wr_be, wr_data, rd_addr, rd_oe
  );

endinterface

// File: rtl/regfile_word.sv
// Purpose : one storage word with per-byte load enables, or a constant zero.
// Latency : load visible on q after the rising edge that samples ld_be.
// Backpressure: none; a byte loads whenever its ld_be bit is set.
// Ports   : clock, clear_n (async clear), ld_be per-byte load, d load data, q stored word.
module regfile_word import regfile_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_TIE = 1'b0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [WIDTH/BYTE-1:0] ld_be,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q
);

  localparam int NB = WIDTH / BYTE;

  generate
    if (ZERO_TIE) begin : g_zero
      // Hardwired zero: no storage, inputs intentionally ignored.
      logic unused_zero;
      assign unused_zero = ^{clock, clear_n, ld_be, d};
      assign q = '0;
    end else begin : g_store
      // Load enables select between hold and new data per byte; the clock runs free.
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          q <= '0;
        end else begin
          for (int k = 0; k < NB; k++) begin
            if (ld_be[k]) q[k*BYTE +: BYTE] <= d[k*BYTE +: BYTE];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/regfile_param.sv
// Purpose : multi-read, single-write register file with byte enables, zero reg, bypass.
// Latency : reads combinational (RD_REG=0) or one cycle (RD_REG=1); writes land on the edge.
// Backpressure: none; every cycle accepts one write and NUM_RD reads.
// Ports   : clock, clear_n (async clear), bus (slave: write port, rd_addr, rd_oe),
//           rd_data packed read data, high-Z per slice whose rd_oe is low.
module regfile_param import regfile_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic                    clock,
  input  logic                    clear_n,
  regfile_param_if.slave          bus,
  output wire [NUM_RD*WIDTH-1:0]  rd_data
);

  localparam int AW = clog2(DEPTH);
  localparam int NB = WIDTH / BYTE;

  logic [WIDTH-1:0] word_q [DEPTH];

  // Write decode: each word gets the byte enables only when addressed.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [NB-1:0] ld_be;
      assign ld_be = (bus.wr_en && (bus.wr_addr == AW'(i))) ? bus.wr_be : '0;

      regfile_word #(
        .WIDTH    (WIDTH),
        .ZERO_TIE ((ZERO_REG != 0) && (i == 0))
      ) u_word (
        .clock   (clock),
        .clear_n (clear_n),
        .ld_be   (ld_be),
        .d       (bus.wr_data),
        .q       (word_q[i])
      );
    end
  endgenerate

  // Read ports: mux, optional bypass merge, optional register, tristate driver.
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] rd_next;
      logic [WIDTH-1:0] rd_out;

      assign addr = bus.rd_addr[slice_lsb(p, AW) +: AW];

      always_comb begin
        rd_next = word_q[addr];
        if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr)) begin
          for (int k = 0; k < NB; k++) begin
            if (bus.wr_be[k]) rd_next[k*BYTE +: BYTE] = bus.wr_data[k*BYTE +: BYTE];
          end
        end
        // Zero reg overrides bypass; during clear the storage is zero, so a
        // bypassed write (which will be lost) must not show either.
        if (!clear_n || ((ZERO_REG != 0) && (addr == '0))) rd_next = '0;
      end

      if (RD_REG != 0) begin : g_reg
        // Advances regardless of rd_oe; only the driver below is gated.
        logic [WIDTH-1:0] rd_q;
        always_ff @(posedge clock or negedge clear_n) begin
          if (!clear_n) rd_q <= '0;
          else          rd_q <= rd_next;
        end
        assign rd_out = rd_q;
      end else begin : g_comb
        assign rd_out = rd_next;
      end

      assign rd_data[slice_lsb(p, WIDTH) +: WIDTH] = bus.rd_oe[p] ? rd_out : {WIDTH{1'bz}};
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Purpose : directed checks of regfile_param in four configurations plus a modelled sweep.
// Latency : n/a.
// Backpressure: n/a.
module tb_regfile_param;

  logic clock = 1'b0;
  logic clear_n;

  always #5 clock = ~clock;

  regfile_param_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) bus ();
  regfile_param_if #(.WIDTH(16), .DEPTH(8),  .NUM_RD(3)) bus16 ();

  wire [63:0] rd_a;  // bypass, combinational
  wire [63:0] rd_b;  // no bypass, combinational
  wire [63:0] rd_c;  // bypass, registered read
  wire [47:0] rd_d;  // 16-bit x 8, three ports

  regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .RD_REG(0))
    u_a (.clock(clock), .clear_n(clear_n), .bus(bus), .rd_data(rd_a));
  regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .RD_REG(0))
    u_b (.clock(clock), .clear_n(clear_n), .bus(bus), .rd_data(rd_b));
  regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .RD_REG(1))
    u_c (.clock(clock), .clear_n(clear_n), .bus(bus), .rd_data(rd_c));
  regfile_param #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1), .RD_REG(0))
    u_d (.clock(clock), .clear_n(clear_n), .bus(bus16), .rd_data(rd_d));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
    step();
    bus.wr_en = 1'b0;
    #1;
  endtask

  // Scoreboard state for the 16-bit sweep.
  logic [15:0] mem16 [8];
  logic        s_we;
  logic [2:0]  s_wa;
  logic [1:0]  s_be;
  logic [15:0] s_wd;
  logic [2:0]  s_ra [3];
  logic [47:0] s_exp;

  function automatic logic [15:0] model_rd(input logic [2:0] ra);
    logic [15:0] v;
    v = mem16[ra];
    if (s_we && s_wa == ra) begin
      if (s_be[0]) v[7:0]  = s_wd[7:0];
      if (s_be[1]) v[15:8] = s_wd[15:8];
    end
    if (ra == 3'd0) v = 16'h0;
    return v;
  endfunction

  initial begin
    clear_n       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_be     = '0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    bus.rd_oe     = 2'b11;
    bus16.wr_en   = 1'b0;
    bus16.wr_addr = '0;
    bus16.wr_be   = '0;
    bus16.wr_data = '0;
    bus16.rd_addr = '0;
    bus16.rd_oe   = 3'b111;
    for (int i = 0; i < 8; i++) mem16[i] = 16'h0;

    // Reset state: enabled ports read zero, disabled port floats.
    #2;
    check("rst_a", rd_a, 64'h0);
    check("rst_c", rd_c, 64'h0);
    check("rst_d", {16'h0, rd_d}, 64'h0);
    bus.rd_oe = 2'b01;
    #1;
    check("rst_a_p0", rd_a[31:0], 64'h0);
    check("rst_a_p1_z", 64'(rd_a[63:32] === 32'hzzzzzzzz), 64'd1);
    bus.rd_oe = 2'b11;
    clear_n = 1'b1;
    step();

    // Reset mid-operation, without a clock edge.
    set_rd(5'd5, 5'd5);
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    check("t1_a_wr", rd_a[31:0], 64'hDEADBEEF);
    check("t1_b_wr", rd_b[31:0], 64'hDEADBEEF);
    clear_n = 1'b0;
    #1;
    check("t1_a_clr", rd_a, 64'h0);
    check("t1_b_clr", rd_b[31:0], 64'h0);
    check("t1_c_clr", rd_c, 64'h0);
    clear_n = 1'b1;
    #1;
    wr(5'd5, 32'h1, 4'hF);
    check("t1_a_after", rd_a[31:0], 64'h1);
    check("t1_a_p1_same", rd_a[63:32], 64'h1);
    check("t1_b_after", rd_b[31:0], 64'h1);
    check("t1_c_after", rd_c[31:0], 64'h1);

    // Reset and write on the same edge: write is lost.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd6;
    bus.wr_data = 32'h77;
    bus.wr_be   = 4'hF;
    set_rd(5'd6, 5'd6);
    clear_n = 1'b0;
    #1;
    check("rw_a_during", rd_a[31:0], 64'h0);
    step();
    clear_n   = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    check("rw_a_lost", rd_a[31:0], 64'h0);
    check("rw_b_lost", rd_b[31:0], 64'h0);

    // Byte enables.
    wr(5'd3, 32'h11223344, 4'hF);
    wr(5'd3, 32'hAABBCCDD, 4'b0101);
    set_rd(5'd3, 5'd3);
    #1;
    check("be_a", rd_a[31:0], 64'h11BB33DD);
    check("be_b", rd_b[31:0], 64'h11BB33DD);
    wr(5'd3, 32'hFFFFFFFF, 4'h0);
    check("be_zero_noop", rd_a[31:0], 64'h11BB33DD);

    // Zero register.
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    set_rd(5'd0, 5'd0);
    #1;
    check("z_a", rd_a, 64'h0);
    check("z_b", rd_b, 64'h0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 32'hFFFFFFFF;
    bus.wr_be   = 4'hF;
    #1;
    check("z_a_bypass", rd_a, 64'h0);
    step();
    bus.wr_en = 1'b0;

    // Bypass versus no bypass.
    wr(5'd7, 32'h5, 4'hF);
    set_rd(5'd7, 5'd7);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'h9;
    bus.wr_be   = 4'hF;
    #1;
    check("byp_a_p0", rd_a[31:0], 64'h9);
    check("byp_a_p1", rd_a[63:32], 64'h9);
    check("byp_b_p0", rd_b[31:0], 64'h5);
    step();
    bus.wr_en = 1'b0;
    #1;
    check("byp_a_post", rd_a[31:0], 64'h9);
    check("byp_b_post", rd_b[31:0], 64'h9);

    // Registered read latency and output enable.
    set_rd(5'd3, 5'd7);
    step();
    check("reg_c_p0", rd_c[31:0], 64'h11BB33DD);
    check("reg_c_p1", rd_c[63:32], 64'h9);
    set_rd(5'd7, 5'd7);
    #1;
    check("reg_c_hold", rd_c[31:0], 64'h11BB33DD);
    step();
    check("reg_c_new", rd_c[31:0], 64'h9);
    bus.rd_oe = 2'b10;
    #1;
    check("oe_c_p0_z", 64'(rd_c[31:0] === 32'hzzzzzzzz), 64'd1);
    check("oe_c_p1", rd_c[63:32], 64'h9);
    check("oe_a_p0_z", 64'(rd_a[31:0] === 32'hzzzzzzzz), 64'd1);
    set_rd(5'd3, 5'd7);
    step();
    bus.rd_oe = 2'b11;
    #1;
    check("oe_c_advanced", rd_c[31:0], 64'h11BB33DD);

    // 16-bit x 8 x 3-port sweep against the scoreboard.
    for (int n = 0; n < 1000; n++) begin
      s_we = 1'($urandom_range(0, 1));
      s_wa = 3'($urandom_range(0, 7));
      s_be = 2'($urandom_range(0, 3));
      s_wd = 16'($urandom);
      for (int p = 0; p < 3; p++) begin
        s_ra[p] = ($urandom_range(0, 3) == 0) ? s_wa : 3'($urandom_range(0, 7));
      end
      bus16.wr_en   = s_we;
      bus16.wr_addr = s_wa;
      bus16.wr_be   = s_be;
      bus16.wr_data = s_wd;
      bus16.rd_addr = {s_ra[2], s_ra[1], s_ra[0]};
      #1;
      s_exp = {model_rd(s_ra[2]), model_rd(s_ra[1]), model_rd(s_ra[0])};
      check("sweep", {16'h0, rd_d}, {16'h0, s_exp});
      if (s_we && s_wa != 3'd0) begin
        if (s_be[0]) mem16[s_wa][7:0]  = s_wd[7:0];
        if (s_be[1]) mem16[s_wa][15:8] = s_wd[15:8];
      end
      step();
    end
    bus16.wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-read, single-write register file; generalises the single 32-bit enable/tristate register to WIDTH x DEPTH words.
- Adds byte-lane write enables, an optional hardwired-zero register 0, write-through bypass and an optional registered read stage.
- Sits in the CPU datapath as the architectural register file; read outputs can share a bus through high-Z.

Parameters:
- WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; power of two, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 means word 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 means a same-cycle write to the read address is forwarded to that read port.
- RD_REG, 0, 0 gives combinational read; 1 registers read data, adding 1 cycle of latency.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  log2(DEPTH)  write address.
- wr_be  in  WIDTH/8  byte-lane enables; bit k covers bits [8k+7:8k].
- wr_data  in  WIDTH  write data.
- rd_addr  in  NUM_RD*log2(DEPTH)  packed read addresses; port p uses slice p.
- rd_oe  in  NUM_RD  per-port output enable.
- rd_data  out  NUM_RD*WIDTH  packed read data; a slice is high-Z when its port is disabled.

Behaviour:
- Reset: clear_n low clears all words to 0 and clears RD_REG pipeline registers to 0, without waiting for a clock edge. rd_data is high-Z for ports with rd_oe=0 and 0 for ports with rd_oe=1. Release is synchronous-safe: the first write is accepted on the first rising edge with clear_n high.
- Write: on a rising edge with wr_en=1, word[wr_addr] byte k takes wr_data byte k for each wr_be[k]=1; other bytes hold. wr_en=1 with wr_be=0 is a no-op. Writes to addr 0 are discarded when ZERO_REG=1. No gated clock; the enable is a data-path mux.
- Read, RD_REG=0: rd_data[p] = word[rd_addr[p]] combinationally.
  - BYPASS=1: when wr_en=1 and wr_addr==rd_addr[p], the enabled bytes come from wr_data and the rest from stored data.
  - BYPASS=0: the old value shows until the edge.
- Read, RD_REG=1: address is sampled at edge N and data appears after edge N. The bypass rule is applied at the sample point, so a read-after-write in the same cycle returns the new bytes when BYPASS=1.
- Output enable: rd_oe[p] is combinational in both modes and is not pipelined. rd_oe=0 gives all-Z on that slice. With RD_REG=1 the read pipeline still advances while rd_oe=0.
- Zero register: with ZERO_REG=1, reads of addr 0 return 0 regardless of bypass.
- Simultaneous events:
  - Several ports reading the same address return identical data.
  - A read and a write to the same address follow the bypass rule above.
  - clear_n asserted in the same cycle as wr_en: reset wins and the write is lost.
- Out-of-range: none possible, because DEPTH is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - clog2 function for the address width.
  - BYTE constant = 8.
  - Helper functions to slice packed port vectors.
- One sub-module, regfile_word: a WIDTH-bit word with async active-low clear, per-byte load enables and a zero-tie option.
  - The top instantiates DEPTH of these through a generate loop.
  - The top holds the write decode, the read muxes, the bypass/pipeline stage and the tristate drivers.

Test Plan:
1. Reset mid-operation: write 0xDEADBEEF to r5, then pulse clear_n low between edges -> r5 reads 0x00000000 immediately with no clock edge; a write of 0x1 on the next edge is accepted.
2. Byte enables: r3=0x11223344, then write 0xAABBCCDD with wr_be=4'b0101 -> r3 reads 0x11BB33DD.
3. Zero register: write 0xFFFFFFFF to r0 -> both ports read 0 at addr 0, with BYPASS=1 and with BYPASS=0.
4. Bypass: with r7=0x5 and a same-cycle write of 0x9 to r7 -> port 0 reads 0x9 when BYPASS=1 and 0x5 when BYPASS=0; after the edge both configurations read 0x9.
5. Registered read (RD_REG=1): rd_addr=7 at edge N -> rd_data shows r7 only after edge N. Toggling rd_oe 1->0 -> that slice goes all-Z in the same cycle, while the other port still shows valid data.
6. Parameter sweep: WIDTH=16, DEPTH=8, NUM_RD=3 -> random writes and reads, checked against a scoreboard model for 1000 cycles with no mismatch.
